// File: rtl/y86_pkg.sv
// Y86-64 execute-stage shared definitions.
// Icode, ALU function, condition and CC-bit constants plus the Cnd helper.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam logic [3:0] R_NONE = 4'hF;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  function automatic logic cond_eval(
    input logic [3:0] fn,
    input logic [2:0] f
  );
    logic z;
    logic lt;
    z  = f[CC_ZF];
    lt = f[CC_SF] ^ f[CC_OF];
    case (fn)
      C_ALWAYS: return 1'b1;
      C_LE:     return lt | z;
      C_L:      return lt;
      C_E:      return z;
      C_NE:     return !z;
      C_GE:     return !lt;
      C_G:      return !lt & !z;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/add64.sv
// Carry-in ripple-free adder shared by ADD and SUB paths.
// Ports: a, b, cin -> sum (modulo 2^WIDTH).
module add64 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b + {{(WIDTH-1){1'b0}}, cin};

endmodule

// File: rtl/alu64.sv
// Combinational Y86 ALU: add/sub/and/xor with ZF/SF/OF flags.
// Ports: alu_a, alu_b, alufun -> result, zf, sf, of.
module alu64
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [3:0]       alufun,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  logic             sub;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             sa;
  logic             sb;
  logic             sr;

  // SUB reuses the adder as B + ~A + 1
  assign sub    = (alufun == ALU_SUB);
  assign addend = sub ? ~alu_a : alu_a;

  add64 #(.WIDTH(WIDTH)) u_add (
    .a   (alu_b),
    .b   (addend),
    .cin (sub),
    .sum (sum)
  );

  assign sa = alu_a[WIDTH-1];
  assign sb = alu_b[WIDTH-1];
  assign sr = sum[WIDTH-1];

  always_comb begin
    result = sum;
    of     = 1'b0;
    case (alufun)
      ALU_ADD: of = (sa == sb) && (sr != sa);
      ALU_SUB: of = (sb != sa) && (sr != sb);
      ALU_AND: result = alu_b & alu_a;
      ALU_XOR: result = alu_b ^ alu_a;
      default: result = sum;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[WIDTH-1];

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, ALU, CC register, Cnd, output buffer.
// Ports: in_* valid/ready from decode, out_* valid/ready to memory, cc flags.
module execute_stage
  import y86_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int STACK_DELTA = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_icode,
  input  logic [3:0]       in_ifun,
  input  logic [WIDTH-1:0] in_valA,
  input  logic [WIDTH-1:0] in_valB,
  input  logic [WIDTH-1:0] in_valC,
  input  logic [3:0]       in_dstE,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [3:0]       out_ifun,
  output logic [WIDTH-1:0] out_valE,
  output logic [WIDTH-1:0] out_valA,
  output logic [3:0]       out_dstE,
  output logic             out_cnd,
  output logic             out_err,
  output logic [2:0]       cc
);

  localparam logic [WIDTH-1:0] DELTA = WIDTH'(STACK_DELTA);

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alufun;
  logic             zf;
  logic             sf;
  logic             of;
  logic             cnd;
  logic             err;
  logic             halted;
  logic             accept;
  logic             is_opq;
  logic             is_cond;

  assign is_opq  = (in_icode == I_OPQ);
  assign is_cond = (in_icode == I_RRMOVQ) || (in_icode == I_JXX);

  always_comb begin
    alu_a = '0;
    case (in_icode)
      I_RRMOVQ, I_OPQ:            alu_a = in_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = in_valC;
      I_CALL, I_PUSHQ:            alu_a = -DELTA;
      I_RET, I_POPQ:              alu_a = DELTA;
      default:                    alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (in_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ,
      I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = in_valB;
      default:                        alu_b = '0;
    endcase
  end

  assign alufun = is_opq ? in_ifun : ALU_ADD;

  alu64 #(.WIDTH(WIDTH)) u_alu (
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alufun (alufun),
    .result (alu_res),
    .zf     (zf),
    .sf     (sf),
    .of     (of)
  );

  // Cnd sees the flags from before this instruction's own update
  assign cnd = is_cond ? cond_eval(in_ifun, cc) : 1'b1;

  assign err = (in_icode > I_POPQ)
             || (is_opq && (in_ifun > ALU_XOR))
             || (is_cond && (in_ifun > C_G));

  assign in_ready = !halted && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_icode <= '0;
      out_ifun  <= '0;
      out_valE  <= '0;
      out_valA  <= '0;
      out_dstE  <= '0;
      out_cnd   <= 1'b0;
      out_err   <= 1'b0;
      cc        <= 3'b100;
      halted    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_icode <= in_icode;
      out_ifun  <= in_ifun;
      out_valE  <= alu_res;
      out_valA  <= in_valA;
      out_dstE  <= (in_icode == I_RRMOVQ && !cnd) ? R_NONE : in_dstE;
      out_cnd   <= cnd;
      out_err   <= err;
      if (is_opq && !err)
        cc <= {zf, sf, of};
      if (in_icode == I_HALT || err)
        halted <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
